// File: rtl/addsub_pkg.sv
// Shared types and constants for the pipelined adder/subtractor.
// Per-stage control payload; operand and partial-result words travel in parallel arrays.
package addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_BLOCK = 8;

  // Control travelling with each pipeline slot; sign bits are from the original operands.
  typedef struct packed {
    logic vld;
    logic sub;
    logic carry;
    logic sign_a;
    logic sign_b;
  } stage_meta_t;

  function automatic logic signed_ovf(input logic sub, input logic sign_a,
                                      input logic sign_b, input logic sign_r);
    return (sub ? (sign_a != sign_b) : (sign_a == sign_b)) && (sign_r != sign_a);
  endfunction

endpackage

// File: rtl/cla_block.sv
// BLOCK-bit carry-lookahead slice: sum and carry-out from a, b and carry-in.
// Purely combinational, no latency, no backpressure.
module cla_block
  import addsub_pkg::*;
#(
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   c;
  logic             acc;
  logic             pp;

  assign g = a & b;
  assign p = a ^ b;

  // Each carry is flattened into a sum of products of g, p and cin (no ripple).
  always_comb begin
    c    = '0;
    acc  = 1'b0;
    pp   = 1'b0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      acc = g[i];
      pp  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc = acc | (pp & g[j]);
        pp  = pp & p[j];
      end
      c[i+1] = acc | (pp & cin);
    end
  end

  assign sum  = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/sub, one BLOCK-bit CLA slice per stage; ADDSUB_SAT_EN clamps on overflow.
// Latency STAGES cycles, 1 op/cycle; outputs registered.
// Backpressure: global stall while out_valid && !out_ready; in_ready is combinational.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             ovf
);

  localparam int STAGES = WIDTH / BLOCK;

  if ((WIDTH % BLOCK) != 0 || STAGES < 1) begin : g_bad_cfg
    $error("pipelined_addsub: WIDTH must be a non-zero multiple of BLOCK");
  end

  logic [WIDTH-1:0] a_in    [STAGES];
  logic [WIDTH-1:0] b_in    [STAGES];
  logic [WIDTH-1:0] res_in  [STAGES];
  stage_meta_t      meta_in [STAGES];

  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] b_q     [STAGES];
  logic [WIDTH-1:0] res_q   [STAGES];
  stage_meta_t      meta_q  [STAGES];
  logic             ovf_q;
  logic             stall;

  assign stall    = meta_q[STAGES-1].vld && !out_ready;
  assign in_ready = !stall;

  // Subtract enters as a + ~b + 1; the +1 rides in as the stage-0 carry.
  assign a_in[0]    = a;
  assign b_in[0]    = (op == OP_ADD) ? b : ~b;
  assign res_in[0]  = '0;
  assign meta_in[0] = '{vld: in_valid, sub: (op == OP_SUB), carry: (op == OP_SUB),
                        sign_a: a[WIDTH-1], sign_b: b[WIDTH-1]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * BLOCK;
    // Operand bits at or above this mask are still needed by later stages.
    localparam logic [WIDTH-1:0] UPPER = {WIDTH{1'b1}} << ((k + 1) * BLOCK);

    logic [BLOCK-1:0] sum;
    logic             cout;
    logic [WIDTH-1:0] res_nxt;
    logic [WIDTH-1:0] res_store;

    if (k > 0) begin : g_link
      assign a_in[k]    = a_q[k-1];
      assign b_in[k]    = b_q[k-1];
      assign res_in[k]  = res_q[k-1];
      assign meta_in[k] = meta_q[k-1];
    end

    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a    (a_in[k][LO +: BLOCK]),
      .b    (b_in[k][LO +: BLOCK]),
      .cin  (meta_in[k].carry),
      .sum  (sum),
      .cout (cout)
    );

    always_comb begin
      res_nxt = res_in[k];
      res_nxt[LO +: BLOCK] = sum;
    end

    if (k == STAGES - 1) begin : g_tail
      logic ovf_nxt;

      assign ovf_nxt = signed_ovf(meta_in[k].sub, meta_in[k].sign_a,
                                  meta_in[k].sign_b, res_nxt[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
      assign res_store = ovf_nxt ? {meta_in[k].sign_a, {(WIDTH-1){!meta_in[k].sign_a}}}
                                 : res_nxt;
`else
      assign res_store = res_nxt;
`endif

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (!stall && meta_in[k].vld) begin
          ovf_q <= ovf_nxt;
        end
      end
    end else begin : g_mid
      assign res_store = res_nxt;
    end

    // Bubbles advance only their valid bit; data registers load on real transfers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        meta_q[k] <= '0;
        res_q[k]  <= '0;
        a_q[k]    <= '0;
        b_q[k]    <= '0;
      end else if (!stall) begin
        if (meta_in[k].vld) begin
          meta_q[k] <= '{vld: 1'b1, sub: meta_in[k].sub, carry: cout,
                         sign_a: meta_in[k].sign_a, sign_b: meta_in[k].sign_b};
          res_q[k]  <= res_store;
          a_q[k]    <= a_in[k] & UPPER;
          b_q[k]    <= b_in[k] & UPPER;
        end else begin
          meta_q[k].vld <= 1'b0;
        end
      end
    end
  end

  assign out_valid = meta_q[STAGES-1].vld;
  assign result    = res_q[STAGES-1];
  assign carry_out = meta_q[STAGES-1].carry;
  assign ovf       = ovf_q;

endmodule
